pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Parametrised instruction-fetch PC generator for the IF stage.
- Drives the instruction-memory address and enable after reset release.
- Advances sequentially and honours a pipeline stall and an instruction-memory grant.
- Redirects on branch and on flush (exception/eret). A branch that arrives while fetch is held is captured and applied later, not lost.

Parameters:
ADDR_W, 32, width of the PC and of all target addresses
RESET_VEC, 32'h00000000, first fetch address after reset (ADDR_W bits)
INST_BYTES, 4, sequential increment in bytes

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
stall_i  in  1  pipeline stall for IF (1 = hold PC)
imem_gnt_i  in  1  instruction memory accepted the current fetch this cycle
branch_flag_i  in  1  branch taken, from ID
branch_target_i  in  ADDR_W  branch target
flush_i  in  1  pipeline flush / exception redirect
flush_addr_i  in  ADDR_W  flush target (handler or EPC)
pc_o  out  ADDR_W  current fetch address
ce_o  out  1  instruction-memory chip enable; also the fetch request
redirect_pend_o  out  1  a captured branch is waiting to be applied
misalign_o  out  1  misaligned-target flag (optional feature)

Behaviour:
- Reset state, applied while rst=1 at a clk edge:
  - ce_o=0, pc_o=RESET_VEC, redirect_pend_o=0, misalign_o=0.
  - State machine goes to IDLE. Any pending redirect is discarded.
- States:
  - IDLE: entered on reset. On the first edge with rst=0, go to RUN and set ce_o<=1. pc_o stays RESET_VEC. All redirect inputs are ignored in IDLE.
  - RUN: normal fetch. Stays in RUN until rst.
- In RUN, adv = ~stall_i & imem_gnt_i.
- Next-PC priority in RUN, evaluated every edge:
  1. flush_i=1: pc_o<=flush_addr_i regardless of adv or stall. Clears any pending redirect. Flush has precedence over a simultaneous branch; that branch is dropped.
  2. Else branch_flag_i=1 with adv=1: pc_o<=branch_target_i. Pending is cleared.
  3. Else branch_flag_i=1 with adv=0: capture branch_target_i into the pending register and set redirect_pend_o<=1. pc_o holds. A newer branch overwrites an older pending one.
  4. Else redirect_pend_o=1 with adv=1: pc_o<=pending address and redirect_pend_o<=0.
  5. Else adv=1: pc_o<=pc_o+INST_BYTES, modulo 2^ADDR_W. 0xFFFFFFFC+4 wraps to 0 with no flag.
  6. Else: hold.
- Latency: every redirect appears on pc_o one cycle after the accepting edge.
- ce_o stays 1 in RUN, including while stalled. The request is held stable: pc_o does not change while ce_o=1 and imem_gnt_i=0, except on flush.
- Reset mid-operation: rst wins over all inputs on the same edge.

Optional Feature:
- Macro: PC_MISALIGN_CHECK_EN.
- Defined:
  - Any redirect loaded into pc_o (flush, branch, or pending) with a target where target mod INST_BYTES != 0 sets misalign_o<=1 on the same edge pc_o updates.
  - misalign_o is sticky until the next flush or reset. pc_o is still loaded unmodified.
- Undefined: misalign_o is tied to 0. The port remains present.

Test Plan:
- Reset and start: rst=1 for 3 cycles, then 0, with stall_i=0 and imem_gnt_i=1.
  -> ce_o=0 and pc_o=0 during reset. ce_o=1 one cycle after release.
  -> pc_o then sequences 0x0, 0x4, 0x8, 0xC.
- Stall and grant hold: stall_i=1 for 2 cycles at pc_o=0x8, then imem_gnt_i=0 for 1 cycle.
  -> pc_o stays 0x8 for those 3 cycles, then moves to 0xC.
- Branch during stall: at pc_o=0x10 with stall_i=1, pulse branch_flag_i with target 0x100.
  -> redirect_pend_o=1 and pc_o=0x10 while stalled.
  -> The edge after stall_i drops gives pc_o=0x100 and redirect_pend_o=0.
- Flush during stall with a pending branch: pending=0x100, stall_i=1, flush_i=1 with flush_addr_i=0x180.
  -> Next cycle pc_o=0x180 and redirect_pend_o=0. The pending branch is never taken.
- Simultaneous flush and branch: flush_addr_i=0x200, branch_target_i=0x300, stall_i=0.
  -> pc_o=0x200.
- Wrap and misalign: pc_o=0xFFFFFFFC with adv=1 -> pc_o=0x0. Branch to 0x102 with the macro defined -> pc_o=0x102 and misalign_o=1. A later flush clears misalign_o to 0.

Source files
------------

// File: rtl/pc_gen.sv
// Instruction-fetch PC generator: sequential fetch with stall/grant hold, branch and flush redirects.
// Optional PC_MISALIGN_CHECK_EN enables a sticky misaligned-redirect flag on misalign_o.
module pc_gen #(
  parameter int unsigned          ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]    RESET_VEC  = '0,
  parameter int unsigned          INST_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              imem_gnt_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_addr_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              ce_o,
  output logic              redirect_pend_o,
  output logic              misalign_o
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              pend_q, pend_d;
  logic              ce_q, ce_d;
  logic              adv;

  assign adv = ~stall_i & imem_gnt_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_VEC;
      pend_addr_q <= '0;
      pend_q      <= 1'b0;
      ce_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_addr_q <= pend_addr_d;
      pend_q      <= pend_d;
      ce_q        <= ce_d;
    end
  end

  // Redirect priority: flush, accepted branch, held branch capture, pending replay, sequential.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_addr_d = pend_addr_q;
    pend_d      = pend_q;
    ce_d        = ce_q;
    case (state_q)
      IDLE: begin
        state_d = RUN;
        ce_d    = 1'b1;
      end
      RUN: begin
        if (flush_i) begin
          pc_d   = flush_addr_i;
          pend_d = 1'b0;
        end else if (branch_flag_i && adv) begin
          pc_d   = branch_target_i;
          pend_d = 1'b0;
        end else if (branch_flag_i) begin
          pend_addr_d = branch_target_i;
          pend_d      = 1'b1;
        end else if (pend_q && adv) begin
          pc_d   = pend_addr_q;
          pend_d = 1'b0;
        end else if (adv) begin
          pc_d = pc_q + ADDR_W'(INST_BYTES);
        end
      end
      default: begin
        state_d = IDLE;
        ce_d    = 1'b0;
      end
    endcase
  end

`ifdef PC_MISALIGN_CHECK_EN
  logic mis_q, mis_d;

  function automatic logic is_misaligned(input logic [ADDR_W-1:0] a);
    return (a % ADDR_W'(INST_BYTES)) != '0;
  endfunction

  // A flush restarts the sticky flag from its own target; other redirects only accumulate.
  always_comb begin
    mis_d = mis_q;
    if (state_q == RUN) begin
      if (flush_i)
        mis_d = is_misaligned(flush_addr_i);
      else if (branch_flag_i && adv)
        mis_d = mis_q | is_misaligned(branch_target_i);
      else if (!branch_flag_i && pend_q && adv)
        mis_d = mis_q | is_misaligned(pend_addr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) mis_q <= 1'b0;
    else     mis_q <= mis_d;
  end

  assign misalign_o = mis_q;
`else
  assign misalign_o = 1'b0;
`endif

  assign pc_o            = pc_q;
  assign ce_o            = ce_q;
  assign redirect_pend_o = pend_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: reference model checked every cycle plus literal expectations.
module tb_pc_gen;
  localparam int ADDR_W = 32;
`ifdef PC_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              stall_i = 1'b0;
  logic              imem_gnt_i = 1'b1;
  logic              branch_flag_i = 1'b0;
  logic [ADDR_W-1:0] branch_target_i = '0;
  logic              flush_i = 1'b0;
  logic [ADDR_W-1:0] flush_addr_i = '0;
  logic [ADDR_W-1:0] pc_o;
  logic              ce_o;
  logic              redirect_pend_o;
  logic              misalign_o;

  int n_checks = 0;
  int n_fail   = 0;

  pc_gen #(.ADDR_W(ADDR_W), .RESET_VEC(32'h0), .INST_BYTES(4)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .imem_gnt_i(imem_gnt_i),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .flush_i(flush_i), .flush_addr_i(flush_addr_i),
    .pc_o(pc_o), .ce_o(ce_o), .redirect_pend_o(redirect_pend_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  // Reference model: fetch address, request, pending branch, misalign flag.
  logic [ADDR_W-1:0] m_pc, m_pend_addr;
  logic              m_ce, m_pend, m_mis, m_started;
  bit                m_valid = 1'b0;

  always @(posedge clk) begin
    logic go;
    go = ~stall_i & imem_gnt_i;
    m_valid <= 1'b1;
    if (rst) begin
      m_pc <= 32'h0; m_ce <= 1'b0; m_pend <= 1'b0; m_mis <= 1'b0; m_started <= 1'b0;
      m_pend_addr <= 32'h0;
    end else if (!m_started) begin
      m_started <= 1'b1; m_ce <= 1'b1;
    end else if (flush_i) begin
      m_pc <= flush_addr_i; m_pend <= 1'b0;
      m_mis <= MIS_EN && (flush_addr_i % 4 != 0);
    end else if (branch_flag_i && go) begin
      m_pc <= branch_target_i; m_pend <= 1'b0;
      m_mis <= m_mis | (MIS_EN && (branch_target_i % 4 != 0));
    end else if (branch_flag_i) begin
      m_pend <= 1'b1; m_pend_addr <= branch_target_i;
    end else if (m_pend && go) begin
      m_pc <= m_pend_addr; m_pend <= 1'b0;
      m_mis <= m_mis | (MIS_EN && (m_pend_addr % 4 != 0));
    end else if (go) begin
      m_pc <= m_pc + 32'd4;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      n_checks++;
      if (pc_o !== m_pc || ce_o !== m_ce || redirect_pend_o !== m_pend || misalign_o !== m_mis) begin
        n_fail++;
        $display("FAIL model t=%0t pc=%h/%h ce=%b/%b pend=%b/%b mis=%b/%b (got/exp)",
                 $time, pc_o, m_pc, ce_o, m_ce, redirect_pend_o, m_pend, misalign_o, m_mis);
      end
    end
  end

  // Apply inputs for one clock edge, returning at the following negedge.
  task automatic tick(input logic s, input logic g, input logic br, input logic [31:0] bt,
                      input logic fl, input logic [31:0] fa);
    stall_i = s; imem_gnt_i = g; branch_flag_i = br; branch_target_i = bt;
    flush_i = fl; flush_addr_i = fa;
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  initial begin
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 0, 0, 0, 0);
      chk("rst_ce", ce_o, 0);
      chk("rst_pc", pc_o, 32'h0);
      chk("rst_pend", redirect_pend_o, 0);
    end
    rst = 1'b0;
    tick(0, 1, 0, 0, 1, 32'h700);   // flush ignored while leaving IDLE
    chk("start_ce", ce_o, 1);
    chk("start_pc0", pc_o, 32'h0);
    tick(0, 1, 0, 0, 0, 0); chk("seq_4", pc_o, 32'h4);
    tick(0, 1, 0, 0, 0, 0); chk("seq_8", pc_o, 32'h8);
    tick(1, 1, 0, 0, 0, 0); chk("stall1", pc_o, 32'h8);
    tick(1, 1, 0, 0, 0, 0); chk("stall2", pc_o, 32'h8);
    chk("stall_ce", ce_o, 1);
    tick(0, 0, 0, 0, 0, 0); chk("nogrant", pc_o, 32'h8);
    tick(0, 1, 0, 0, 0, 0); chk("seq_c", pc_o, 32'hC);
    tick(0, 1, 0, 0, 0, 0); chk("seq_10", pc_o, 32'h10);
    tick(1, 1, 1, 32'h100, 0, 0);
    chk("br_stall_pend", redirect_pend_o, 1); chk("br_stall_pc", pc_o, 32'h10);
    tick(1, 1, 0, 0, 0, 0);
    chk("br_hold_pend", redirect_pend_o, 1); chk("br_hold_pc", pc_o, 32'h10);
    tick(0, 1, 0, 0, 0, 0);
    chk("br_apply_pc", pc_o, 32'h100); chk("br_apply_pend", redirect_pend_o, 0);
    tick(1, 1, 1, 32'h100, 0, 0); chk("pend2", redirect_pend_o, 1);
    tick(1, 1, 0, 0, 1, 32'h180);
    chk("flush_pc", pc_o, 32'h180); chk("flush_pend", redirect_pend_o, 0);
    tick(0, 1, 0, 0, 0, 0); chk("flush_drop", pc_o, 32'h184);
    tick(0, 1, 1, 32'h300, 1, 32'h200); chk("fl_vs_br", pc_o, 32'h200);
    tick(0, 1, 0, 0, 0, 0); chk("fl_vs_br_next", pc_o, 32'h204);
    tick(0, 1, 0, 0, 1, 32'hFFFF_FFFC); chk("to_top", pc_o, 32'hFFFF_FFFC);
    tick(0, 1, 0, 0, 0, 0); chk("wrap", pc_o, 32'h0);
    tick(0, 1, 1, 32'h102, 0, 0);
    chk("mis_pc", pc_o, 32'h102); chk("mis_set", misalign_o, MIS_EN);
    tick(0, 1, 0, 0, 0, 0);
    chk("mis_seq", pc_o, 32'h106); chk("mis_sticky", misalign_o, MIS_EN);
    tick(0, 1, 0, 0, 1, 32'h400);
    chk("mis_clr_pc", pc_o, 32'h400); chk("mis_clr", misalign_o, 0);
    tick(0, 0, 1, 32'h500, 0, 0); chk("ovr1", pc_o, 32'h400);
    tick(0, 0, 1, 32'h600, 0, 0); chk("ovr2_pend", redirect_pend_o, 1);
    tick(0, 1, 0, 0, 0, 0); chk("ovr_apply", pc_o, 32'h600);
    tick(1, 1, 1, 32'h802, 0, 0);
    tick(0, 1, 0, 0, 0, 0);
    chk("pend_mis_pc", pc_o, 32'h802); chk("pend_mis", misalign_o, MIS_EN);
    rst = 1'b1;
    tick(0, 1, 1, 32'h900, 1, 32'hA00);
    chk("midrst_pc", pc_o, 32'h0); chk("midrst_ce", ce_o, 0);
    chk("midrst_mis", misalign_o, 0);
    rst = 1'b0;
    tick(0, 1, 0, 0, 0, 0); chk("rerun_ce", ce_o, 1); chk("rerun_pc", pc_o, 32'h0);
    for (int i = 0; i < 4; i++) tick(i[0], 1, 0, 0, 0, 0);
    chk("final_pc", pc_o, 32'h8);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
